// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StAck    = 2'd2
  } state_e;

  localparam logic [31:0] BAD_READ_DATA = 32'hDEADBEEF;
  localparam int unsigned LATENCY_MAX   = 15;
  localparam int unsigned CNT_W         = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM.
module mem_array #(
  parameter int unsigned ADDR_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: word RAM, programmable wait states, 4-phase MemReady handshake.
// Optional out-of-range detection with err output when MEM_BOUNDS_CHECK_EN is defined.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        busy
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam cnt_t CntInit = cnt_t'(LATENCY - 1);

  state_e            state;
  cnt_t              cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] mem_idx;
  logic [31:0]       wdata_q;
  logic [31:0]       mem_rdata;
  logic              wr_q;
  logic              oob;
  logic              oob_q;
  logic              commit;
  logic              mem_we;
  logic              unused_addr_bits;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob              = |Address[31:ADDR_W+2];
  assign unused_addr_bits = ^Address[1:0];
`else
  assign oob              = 1'b0;
  assign unused_addr_bits = ^{Address[31:ADDR_W+2], Address[1:0]};
`endif

  assign commit  = (state == StAccess) && (cnt == '0);
  // Reset on the commit edge must win, so the write enable is gated directly.
  assign mem_we  = commit && wr_q && !oob_q && !reset;
  // In idle the RAM already looks up the incoming address so LATENCY=1 reads are ready in time.
  assign mem_idx = (state == StIdle) ? Address[ADDR_W+1:2] : idx_q;

  mem_array #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (mem_idx),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      cnt      <= '0;
      ReadData <= '0;
      MemReady <= 1'b0;
      busy     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      oob_q    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (MemRead || MemWrite) begin
            state   <= StAccess;
            busy    <= 1'b1;
            cnt     <= CntInit;
            idx_q   <= Address[ADDR_W+1:2];
            wdata_q <= WriteData;
            wr_q    <= MemWrite;
            oob_q   <= oob;
          end
        end
        StAccess: begin
          if (commit) begin
            state    <= StAck;
            busy     <= 1'b0;
            MemReady <= 1'b1;
            if (!wr_q) ReadData <= oob_q ? BAD_READ_DATA : mem_rdata;
`ifdef MEM_BOUNDS_CHECK_EN
            err      <= oob_q;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StAck: begin
          if (!MemRead && !MemWrite) begin
            state    <= StIdle;
            MemReady <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (LATENCY 2, 1, 15) against a word-array model.
module tb_data_mem_responder;

  localparam int NDUT = 3;

  function automatic int unsigned lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr   [NDUT];
  logic        mw   [NDUT];
  logic [31:0] addr [NDUT];
  logic [31:0] wd   [NDUT];
  logic [31:0] rd   [NDUT];
  logic        rdy  [NDUT];
  logic        busy [NDUT];
`ifdef MEM_BOUNDS_CHECK_EN
  logic        err  [NDUT];
`endif

  exp_t        sb [NDUT][$];
  logic [31:0] mdl [NDUT][256];
  logic [31:0] last_rd [NDUT];
  logic        rdy_prev [NDUT];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_W (8),
      .LATENCY(lat_of(g))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .MemRead  (mr[g]),
      .MemWrite (mw[g]),
      .Address  (addr[g]),
      .WriteData(wd[g]),
      .ReadData (rd[g]),
      .MemReady (rdy[g]),
      .busy     (busy[g])
`ifdef MEM_BOUNDS_CHECK_EN
      ,
      .err      (err[g])
`endif
    );
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %h, want %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input int i);
    n_vec++;
    n_fail++;
    $display("FAIL %s dut%0d @cyc %0d: got event, want none", name, i, cyc);
  endtask

  // Monitor: every rising MemReady must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (rdy[i] === 1'b1 && rdy_prev[i] !== 1'b1) begin
        if (sb[i].size() == 0) begin
          flag_fail("unexpected_ready", i);
        end else begin
          e = sb[i].pop_front();
          chk("ready_cycle", i, cyc, e.due);
          chk("read_data", i, rd[i], e.rdata);
`ifdef MEM_BOUNDS_CHECK_EN
          chk("err_in_ack", i, err[i], e.err);
`endif
        end
      end
      rdy_prev[i] = rdy[i];
    end
  end

  function automatic bit is_oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return a[31:10] != 0;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic wait_ready(input int i);
    int t = 0;
    while (rdy[i] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) flag_fail("ready_timeout", i);
  endtask

  task automatic push_exp(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   oob = is_oob(a);
    e.due = cyc + lat_of(i) + 1;
    if (w) begin
      if (!oob) mdl[i][a[9:2]] = d;
    end else begin
      last_rd[i] = oob ? 32'hDEADBEEF : mdl[i][a[9:2]];
    end
    e.rdata = last_rd[i];
    e.err   = oob;
    sb[i].push_back(e);
  endtask

  task automatic do_op(input int i, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input bit early);
    @(negedge clk);
    mr[i] = r; mw[i] = w; addr[i] = a; wd[i] = d;
    push_exp(i, w, a, d);
    @(negedge clk);
    chk("busy_in_access", i, busy[i], 1'b1);
    // Inputs wiggled mid-access must not disturb the latched request.
    addr[i] = $urandom;
    wd[i]   = $urandom;
    if (early) begin
      mr[i] = 1'b0; mw[i] = 1'b0;
    end
    wait_ready(i);
    chk("busy_in_ack", i, busy[i], 1'b0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("ready_held", i, rdy[i], 1'b1);
      chk("busy_held", i, busy[i], 1'b0);
    end
    mr[i] = 1'b0; mw[i] = 1'b0;
    @(negedge clk);
    chk("ready_released", i, rdy[i], 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("err_cleared", i, err[i], 1'b0);
`endif
  endtask

  // Write 0xFFFFFFFF to 0x30 on dut0 and reset k cycles into the access.
  task automatic reset_abort(input int k);
    @(negedge clk);
    mw[0] = 1'b1; addr[0] = 32'h30; wd[0] = 32'hFFFF_FFFF;
    repeat (k) @(negedge clk);
    reset = 1'b1; mw[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) last_rd[i] = '0;
    for (int c = 0; c < 4; c++) begin
      chk("ready_after_abort", 0, rdy[0], 1'b0);
      chk("rdata_after_abort", 0, rd[0], 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic reset_in_ack();
    @(negedge clk);
    mr[0] = 1'b1; addr[0] = 32'h10; wd[0] = '0;
    push_exp(0, 1'b0, 32'h10, '0);
    @(negedge clk);
    wait_ready(0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mr[0] = 1'b0;
    chk("ready_after_ack_reset", 0, rdy[0], 1'b0);
    chk("rdata_after_ack_reset", 0, rd[0], 32'h0);
    for (int i = 0; i < NDUT; i++) last_rd[i] = '0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [21:0] up;
    logic [3:0]  ix4;
    logic [1:0]  lo;
    int          kind, hold, nops;
    bit          early;

    reset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; addr[i] = '0; wd[i] = '0; last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_rdata", i, rd[i], 32'h0);
      chk("reset_ready", i, rdy[i], 1'b0);
      chk("reset_busy", i, busy[i], 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
      chk("reset_err", i, err[i], 1'b0);
`endif
    end
    reset = 1'b0;

    // Give the words used below known contents.
    for (int i = 0; i < NDUT; i++)
      for (int w = 0; w < 16; w++)
        do_op(i, 1'b1, 1'b0, 32'(w << 2), $urandom, 0, 1'b0);

    do_op(0, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 0, 1'b0);
    do_op(0, 1'b0, 1'b1, 32'h10, 32'h0, 0, 1'b0);
    do_op(0, 1'b0, 1'b1, 32'h10, 32'h0, 5, 1'b0);
    do_op(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 0, 1'b0);
    do_op(0, 1'b0, 1'b1, 32'h20, 32'h0, 0, 1'b0);
    do_op(0, 1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b0);
    reset_abort(1);
    do_op(0, 1'b0, 1'b1, 32'h30, 32'h0, 0, 1'b0);
    reset_abort(lat_of(0));
    do_op(0, 1'b0, 1'b1, 32'h30, 32'h0, 0, 1'b0);
    reset_in_ack();
    do_op(1, 1'b0, 1'b1, 32'h10, 32'h0, 0, 1'b0);
    do_op(2, 1'b0, 1'b1, 32'h10, 32'h0, 0, 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    do_op(0, 1'b0, 1'b1, 32'h400, 32'h0, 0, 1'b0);
    do_op(0, 1'b1, 1'b0, 32'h400, 32'h55, 0, 1'b0);
    do_op(0, 1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b0);
`endif

    for (int i = 0; i < NDUT; i++) begin
      nops = (i == 2) ? 40 : 150;
      for (int n = 0; n < nops; n++) begin
        kind  = $urandom_range(0, 2);
        up    = ($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'h0;
        ix4   = 4'($urandom);
        lo    = 2'($urandom);
        hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        early = (hold == 0) && ($urandom_range(0, 3) == 0);
        do_op(i, kind != 1, kind != 0, {up, 4'b0, ix4, lo}, $urandom, hold, early);
      end
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < NDUT; i++) chk("scoreboard_drained", i, sb[i].size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
